// File: rtl/rs_issue_arbiter.sv
// rs_issue_arbiter: round-robin pick among reservation stations into a 2-entry issue buffer feeding one FU
module rs_issue_arbiter #(
    parameter int NUM_REQ = 2,
    parameter int DATA_W = 64,
    parameter int ROB_IDX_W = 4,
    parameter int OP_W = 4
) (
    input  logic                           in_clk,
    input  logic                           in_rst,
    input  logic                           in_rob_is_mispred,
    input  logic [NUM_REQ-1:0]             in_req_valid,
    input  logic [NUM_REQ*DATA_W-1:0]      in_req_val_a,
    input  logic [NUM_REQ*DATA_W-1:0]      in_req_val_b,
    input  logic [NUM_REQ*ROB_IDX_W-1:0]   in_req_dst_rob_index,
    input  logic [NUM_REQ*OP_W-1:0]        in_req_op,
    input  logic [NUM_REQ-1:0]             in_req_set_nzcv,
    input  logic [NUM_REQ*4-1:0]           in_req_nzcv,
    output logic [NUM_REQ-1:0]             out_req_grant,
    input  logic                           in_fu_ready,
    output logic                           out_fu_valid,
    output logic [DATA_W-1:0]              out_fu_val_a,
    output logic [DATA_W-1:0]              out_fu_val_b,
    output logic [ROB_IDX_W-1:0]           out_fu_dst_rob_index,
    output logic [OP_W-1:0]                out_fu_op,
    output logic                           out_fu_set_nzcv,
    output logic [3:0]                     out_fu_nzcv,
    output logic [1:0]                     out_occupancy,
    output logic [15:0]                    out_issue_count
);
    localparam int PTR_W = $clog2(NUM_REQ);
    localparam int PW = 2*DATA_W + ROB_IDX_W + OP_W + 5;
    logic [1:0]       occ;
    logic             head;
    logic [PTR_W-1:0] rr_ptr, rr_next, gnt_idx, scan_idx;
    logic [PTR_W:0]   scan;
    logic             found, can_accept, push, pop;
    logic [PW-1:0]    slot [2];
    logic [PW-1:0]    in_pl, head_pl;
    logic [15:0]      cnt;
    always_comb begin
        gnt_idx = '0;
        found = 1'b0;
        scan = '0;
        scan_idx = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            scan = {1'b0, rr_ptr} + (PTR_W+1)'(k);
            scan_idx = (scan >= (PTR_W+1)'(NUM_REQ)) ? PTR_W'(scan - (PTR_W+1)'(NUM_REQ)) : scan[PTR_W-1:0];
            if (!found && in_req_valid[scan_idx]) begin
                gnt_idx = scan_idx;
                found = 1'b1;
            end
        end
    end
    assign can_accept = (occ != 2'd2) && !in_rob_is_mispred && !in_rst;
    assign push = can_accept && found;
    assign out_req_grant = push ? (NUM_REQ'(1) << gnt_idx) : '0;
    assign rr_next = (gnt_idx == PTR_W'(NUM_REQ-1)) ? '0 : gnt_idx + 1'b1;
    assign out_fu_valid = (occ != 2'd0);
    assign pop = out_fu_valid && in_fu_ready && !in_rob_is_mispred;
    assign in_pl = {in_req_val_a[gnt_idx*DATA_W +: DATA_W],
                    in_req_val_b[gnt_idx*DATA_W +: DATA_W],
                    in_req_dst_rob_index[gnt_idx*ROB_IDX_W +: ROB_IDX_W],
                    in_req_op[gnt_idx*OP_W +: OP_W],
                    in_req_set_nzcv[gnt_idx],
                    in_req_nzcv[gnt_idx*4 +: 4]};
    assign head_pl = out_fu_valid ? slot[head] : '0;
    assign {out_fu_val_a, out_fu_val_b, out_fu_dst_rob_index, out_fu_op, out_fu_set_nzcv, out_fu_nzcv} = head_pl;
    assign out_occupancy = occ;
    assign out_issue_count = cnt;
    always_ff @(posedge in_clk) begin
        if (in_rst) begin
            occ <= '0;
            head <= 1'b0;
            rr_ptr <= '0;
            cnt <= '0;
        end else if (in_rob_is_mispred) begin
            occ <= '0;
            head <= 1'b0;
            rr_ptr <= '0;
        end else begin
            if (push) begin
                slot[head ^ occ[0]] <= in_pl;
                rr_ptr <= rr_next;
            end
            if (pop) begin
                head <= ~head;
                cnt <= cnt + 16'd1;
            end
            occ <= occ + 2'(push) - 2'(pop);
        end
    end
endmodule
